rr_index_encoder: RTL and testbench
===================================

Name: rr_index_encoder

Overview:
- Upstream stage of the one-cold pattern decoder.
- Captures 8 sticky request lines and arbitrates among them round-robin.
- Presents the winning request number as a zero-extended WIDTH-bit index with a valid/ready handshake; the index feeds the decoder's data input directly.
- When no index is presented, the output is all-ones, which the decoder treats as its default (out-of-range) pattern.

Parameters:
- WIDTH, 32, width of idx_out; must be >= 3; bits [WIDTH-1:3] are zero whenever idx_valid=1.
- NREQ, 8, number of request lines; fixed at 8 (3-bit index); other values unsupported.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req  input  NREQ  request pulses/levels; each asserted bit sets its pending flag.
- idx_ready  input  1  consumer accepts idx_out this cycle.
- idx_out  output  WIDTH  granted index, zero-extended; all-ones when idx_valid=0.
- idx_valid  output  1  idx_out holds a valid grant.
- pending  output  NREQ  current pending-request register.
- drop_cnt  output  CNT_W  saturating count of cycles in which a request was merged into an already-pending bit.

Behaviour:
- Reset (async assert, synchronous release):
  - pending=0, ptr=7 (so the first search starts at bit 0), state=IDLE.
  - idx_out = all-ones, idx_valid=0, drop_cnt=0.
- Pending register, every cycle: pending_next = (pending & ~clr) | req.
  - clr is one-hot for the granted bit on accept (idx_valid & idx_ready), else 0.
  - Set wins over clear: a req bit equal to the bit being accepted re-pends it.
- Drop counter:
  - Increments by 1 in any cycle where (req & pending & ~clr) != 0.
  - Increments by at most 1 per cycle regardless of how many bits match.
  - Saturates at 2^CNT_W-1, with no wrap.
- State machine with 2 states:
  - IDLE:
    - idx_valid=0, idx_out=all-ones.
    - If the registered pending != 0: search bits ptr+1, ptr+2, ... mod 8 and take the first set bit g.
    - Next cycle: idx_out={0..0,g[2:0]}, idx_valid=1, ptr=g, state=GRANT.
    - Requests arriving this cycle are not visible to this cycle's search.
  - GRANT:
    - idx_out and idx_valid are held stable while idx_ready=0 (no retraction, no change of index).
    - On idx_ready=1: clear pending[g] (subject to set-wins), go to IDLE next cycle.
    - idx_valid=0 in the cycle after accept, giving one mandatory bubble cycle.
- Latency:
  - req asserted in cycle t → pending set at t+1 → idx_valid at t+2.
  - Accept in cycle t → next grant valid at t+2 at the earliest.
- Round-robin fairness: with all 8 bits continuously pending, grants cycle 0,1,...,7,0,... with no starvation.
- idx_ready while idx_valid=0 is ignored.
- All outputs are registered; no combinational path from req or idx_ready to any output.
- Reset asserted mid-GRANT: outputs return to reset values immediately (async); the grant in flight is lost and pending is cleared.

Test Plan:
- Reset behaviour: assert rst mid-GRANT with idx_valid=1, idx_out=5 → same cycle idx_valid=0, idx_out=32'hFFFFFFFF, pending=0, drop_cnt=0; after release with req=0, outputs stay at reset values.
- Single request: req=8'b0000_1000 pulse at t, idx_ready=1 → idx_valid=1 with idx_out=32'd3 at t+2; pending=0 at t+3; idx_valid=0 at t+3.
- Round-robin: req=8'hFF held, idx_ready=1 → accepted index sequence 0,1,2,...,7,0 with exactly one idle cycle between grants; drop_cnt climbs to 255 and stays there.
- Backpressure: pending=8'b0010_0100, idx_ready=0 for 10 cycles → idx_out=32'd2 held constant with idx_valid=1; on ready, next grant is 5, not 2.
- Set-wins: accept grant 6 while req[6]=1 in the same cycle → pending[6] remains 1, drop_cnt unchanged; 6 is granted again only after the other pending bits when they are present.
- Drop saturation with CNT_W=2: req[0] held for 10 cycles while grant 0 is stalled → drop_cnt reaches 3 and holds.

Source files
------------

// File: rtl/rr_index_encoder_if.sv
// Request/grant bundle for rr_index_encoder.
//   req        : sticky request lines into the encoder
//   idx_ready  : consumer accepts idx_out this cycle
//   idx_out    : granted index, zero-extended; all-ones when idx_valid=0
//   idx_valid  : idx_out holds a valid grant
//   pending    : current pending-request register
//   drop_cnt   : saturating count of cycles with a request merged into a pending bit
// Modport master is the encoder side; slave is the requester/consumer side.
interface rr_index_encoder_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 8,
  parameter int unsigned CNT_W = 8
);
  logic [NREQ-1:0]  req;
  logic             idx_ready;
  logic [WIDTH-1:0] idx_out;
  logic             idx_valid;
  logic [NREQ-1:0]  pending;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    input  req,
    input  idx_ready,
    output idx_out,
    output idx_valid,
    output pending,
    output drop_cnt
  );

  modport slave (
    output req,
    output idx_ready,
    input  idx_out,
    input  idx_valid,
    input  pending,
    input  drop_cnt
  );
endinterface

// File: rtl/rr_index_encoder.sv
// Round-robin index encoder: captures 8 sticky request lines, picks the next
// pending one after the last grant and presents its number as a zero-extended
// WIDTH-bit index with a valid/ready handshake. idx_out is all-ones whenever
// no grant is presented.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : rr_index_encoder_if.master (req, idx_ready in; idx_out, idx_valid,
//          pending, drop_cnt out)
module rr_index_encoder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  rr_index_encoder_if.master  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_next;
  logic [NREQ-1:0]  pending, pending_next, clr;
  logic [2:0]       ptr, ptr_next, pick, slot;
  logic             found, accept;
  logic [CNT_W-1:0] drop_cnt, drop_next;
  logic [WIDTH-1:0] idx_out, idx_out_next;
  logic             idx_valid, idx_valid_next;

  assign accept = (state == GRANT) && bus.idx_ready;

  // ptr holds the last granted bit; the 3-bit add wraps the search mod 8.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    slot  = ptr;
    for (int unsigned i = 1; i <= 8; i++) begin
      slot = ptr + 3'(i);
      if (!found && pending[slot]) begin
        found = 1'b1;
        pick  = slot;
      end
    end
  end

  // Set wins over clear: a request on the bit being accepted re-pends it.
  always_comb begin
    clr = '0;
    if (accept) clr[ptr] = 1'b1;
    pending_next = (pending & ~clr) | bus.req;
    drop_next    = drop_cnt;
    if (|(bus.req & pending & ~clr) && (drop_cnt != '1))
      drop_next = drop_cnt + 1'b1;
  end

  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    idx_valid_next = idx_valid;
    idx_out_next   = idx_out;
    case (state)
      IDLE: begin
        idx_valid_next = 1'b0;
        idx_out_next   = '1;
        if (found) begin
          state_next        = GRANT;
          ptr_next          = pick;
          idx_valid_next    = 1'b1;
          idx_out_next      = '0;
          idx_out_next[2:0] = pick;
        end
      end
      GRANT: begin
        if (bus.idx_ready) begin
          state_next     = IDLE;
          idx_valid_next = 1'b0;
          idx_out_next   = '1;
        end
      end
      default: begin
        state_next     = IDLE;
        idx_valid_next = 1'b0;
        idx_out_next   = '1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      ptr       <= 3'd7;
      drop_cnt  <= '0;
      idx_out   <= '1;
      idx_valid <= 1'b0;
    end else begin
      pending   <= pending_next;
      ptr       <= ptr_next;
      drop_cnt  <= drop_next;
      idx_out   <= idx_out_next;
      idx_valid <= idx_valid_next;
    end
  end

  assign bus.idx_out   = idx_out;
  assign bus.idx_valid = idx_valid;
  assign bus.pending   = pending;
  assign bus.drop_cnt  = drop_cnt;

endmodule

// File: tb/tb_rr_index_encoder.sv
// Self-checking bench for rr_index_encoder: directed scenarios plus random
// traffic, compared against a behavioural model and directed constants.
module tb_rr_index_encoder;
  localparam int unsigned WIDTH    = 32;
  localparam int          DROP_MAX = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_index_encoder_if #(.WIDTH(WIDTH), .NREQ(8), .CNT_W(8)) bus ();
  rr_index_encoder_if #(.WIDTH(WIDTH), .NREQ(8), .CNT_W(2)) bus2 ();

  rr_index_encoder #(.WIDTH(WIDTH), .NREQ(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  rr_index_encoder #(.WIDTH(WIDTH), .NREQ(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: set of pending request numbers, last winner, grant flag.
  bit       m_busy;
  int       m_g;
  int       m_ptr;
  int       m_drop;
  bit [7:0] m_pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_g    = 0;
    m_ptr  = 7;
    m_drop = 0;
    m_pend = 8'h00;
  endtask

  task automatic model_step(input bit [7:0] r, input bit rdy);
    bit [7:0] clr;
    clr = 8'h00;
    if (m_busy && rdy) clr = 8'(1 << m_g);
    if (((r & m_pend & ~clr) != 8'h00) && (m_drop < DROP_MAX)) m_drop++;
    if (m_busy) begin
      if (rdy) m_busy = 1'b0;
    end else begin
      for (int k = 1; k <= 8; k++) begin
        int b;
        b = (m_ptr + k) % 8;
        if (m_pend[b]) begin
          m_g    = b;
          m_ptr  = b;
          m_busy = 1'b1;
          break;
        end
      end
    end
    m_pend = (m_pend & ~clr) | r;
  endtask

  task automatic cmp_model();
    check("model_valid", bus.idx_valid, m_busy);
    check("model_idx", bus.idx_out, m_busy ? 32'(m_g) : 32'hFFFF_FFFF);
    check("model_pending", bus.pending, m_pend);
    check("model_drop", bus.drop_cnt, 32'(m_drop));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(bus.req, bus.idx_ready);
    #1;
    cmp_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  int acc_idx[$];
  int acc_at[$];

  initial begin
    rst = 1'b1;
    bus.req = '0;  bus.idx_ready = 1'b0;
    bus2.req = '0; bus2.idx_ready = 1'b0;
    model_reset();

    // Reset state, then stays idle after release with no requests
    #2;
    check("rst_valid", bus.idx_valid, 1'b0);
    check("rst_idx", bus.idx_out, 32'hFFFF_FFFF);
    check("rst_pending", bus.pending, 8'h00);
    check("rst_drop", bus.drop_cnt, 8'h00);
    repeat (2) cycle();
    rst = 1'b0;
    repeat (3) cycle();

    // Single request: pending at t+1, grant 3 at t+2, cleared at t+3
    bus.req = 8'b0000_1000; bus.idx_ready = 1'b1;
    cycle();
    bus.req = '0;
    check("single_pend_t1", bus.pending, 8'h08);
    check("single_valid_t1", bus.idx_valid, 1'b0);
    cycle();
    check("single_valid_t2", bus.idx_valid, 1'b1);
    check("single_idx_t2", bus.idx_out, 32'd3);
    cycle();
    check("single_valid_t3", bus.idx_valid, 1'b0);
    check("single_pend_t3", bus.pending, 8'h00);
    repeat (2) cycle();

    // Round-robin with all requests held
    do_reset();
    bus.req = 8'hFF; bus.idx_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (bus.idx_valid && bus.idx_ready) begin
        acc_idx.push_back(int'(bus.idx_out));
        acc_at.push_back(c);
      end
      cycle();
    end
    check("rr_count", 32'(acc_idx.size() >= 17), 32'd1);
    for (int k = 0; k < 17 && k < acc_idx.size(); k++) begin
      check("rr_order", 32'(acc_idx[k]), 32'(k % 8));
      if (k > 0) check("rr_gap", 32'(acc_at[k] - acc_at[k-1]), 32'd2);
    end
    check("rr_drop_sat", bus.drop_cnt, 8'd255);
    repeat (3) cycle();
    check("rr_drop_hold", bus.drop_cnt, 8'd255);
    bus.req = '0;
    repeat (20) cycle();

    // Backpressure: grant 2 held while stalled, then 5
    do_reset();
    bus.idx_ready = 1'b0;
    bus.req = 8'b0010_0100;
    cycle();
    bus.req = '0;
    cycle();
    for (int c = 0; c < 10; c++) begin
      cycle();
      check("bp_hold_valid", bus.idx_valid, 1'b1);
      check("bp_hold_idx", bus.idx_out, 32'd2);
    end
    bus.idx_ready = 1'b1;
    cycle();
    check("bp_bubble", bus.idx_valid, 1'b0);
    cycle();
    check("bp_next_valid", bus.idx_valid, 1'b1);
    check("bp_next_idx", bus.idx_out, 32'd5);
    repeat (3) cycle();

    // Set-wins: accept 6 while req[6] is high
    do_reset();
    bus.idx_ready = 1'b0;
    bus.req = 8'h40;
    cycle();
    bus.req = '0;
    cycle();
    check("sw_grant6", bus.idx_out, 32'd6);
    bus.req = 8'h05;
    cycle();
    bus.req = 8'h40; bus.idx_ready = 1'b1;
    cycle();
    bus.req = '0;
    check("sw_pending", bus.pending, 8'h45);
    check("sw_drop", bus.drop_cnt, 8'd0);
    acc_idx.delete();
    for (int c = 0; c < 12; c++) begin
      if (bus.idx_valid && bus.idx_ready) acc_idx.push_back(int'(bus.idx_out));
      cycle();
    end
    check("sw_count", 32'(acc_idx.size()), 32'd3);
    if (acc_idx.size() == 3) begin
      check("sw_order0", 32'(acc_idx[0]), 32'd0);
      check("sw_order1", 32'(acc_idx[1]), 32'd2);
      check("sw_order2", 32'(acc_idx[2]), 32'd6);
    end

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      bus.req = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      bus.idx_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    bus.req = '0; bus.idx_ready = 1'b1;
    repeat (20) cycle();

    // Drop counter saturation on the 2-bit instance
    do_reset();
    bus2.req = 8'h01; bus2.idx_ready = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      cycle();
      if (c == 3) check("sat2_c3", bus2.drop_cnt, 2'd2);
      if (c == 4) check("sat2_c4", bus2.drop_cnt, 2'd3);
    end
    check("sat2_hold", bus2.drop_cnt, 2'd3);
    check("sat2_valid", bus2.idx_valid, 1'b1);
    check("sat2_idx", bus2.idx_out, 32'd0);
    bus2.req = '0;

    // Reset asserted mid-grant of index 5
    do_reset();
    bus.idx_ready = 1'b0;
    bus.req = 8'h20;
    cycle();
    bus.req = '0;
    cycle();
    bus.req = 8'h20;
    cycle();
    bus.req = '0;
    check("mid_valid_pre", bus.idx_valid, 1'b1);
    check("mid_idx_pre", bus.idx_out, 32'd5);
    check("mid_drop_pre", bus.drop_cnt, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_valid", bus.idx_valid, 1'b0);
    check("mid_idx", bus.idx_out, 32'hFFFF_FFFF);
    check("mid_pending", bus.pending, 8'h00);
    check("mid_drop", bus.drop_cnt, 8'h00);
    model_reset();
    cycle();
    rst = 1'b0;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
